// File: rtl/rbuf_pkg.sv
// Shared definitions for the tap-streaming sample history buffer.
// Holds the default window geometry, the burst state encoding and the
// modulo-M pointer arithmetic used by both the top and the address generator.
package rbuf_pkg;

  localparam int unsigned DefM  = 6;   // window length (taps)
  localparam int unsigned DefW  = 12;  // sample width
  localparam int unsigned DefAW = 3;   // pointer/index width, 2**DefAW >= DefM

  typedef enum logic [0:0] {
    StIdle,
    StRead
  } state_e;

  // (a + b) mod m, valid for a, b < m; avoids a real divider.
  function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned m);
    int unsigned s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

  // (a - b) mod m, valid for a, b < m.
  function automatic int unsigned mod_sub(int unsigned a, int unsigned b, int unsigned m);
    int unsigned s;
    s = a + m - b;
    if (s >= m) s = s - m;
    return s;
  endfunction

endpackage

// File: rtl/rbuf_tap_reader_if.sv
// Tap stream between the history buffer and the time-shared FIR MAC.
// Ports (master = buffer side):
//   tap_valid  tap_data/tap_idx/tap_last are valid
//   tap_ready  sink accepts the tap this cycle
//   tap_data   sample value for tap tap_idx
//   tap_idx    tap index (0 = newest sample)
//   tap_last   final tap of the burst
interface rbuf_tap_reader_if #(
  parameter int unsigned W  = 12,
  parameter int unsigned AW = 3
) ();

  logic          tap_valid;
  logic          tap_ready;
  logic [W-1:0]  tap_data;
  logic [AW-1:0] tap_idx;
  logic          tap_last;

  modport master (
    output tap_valid,
    output tap_data,
    output tap_idx,
    output tap_last,
    input  tap_ready
  );

  modport slave (
    input  tap_valid,
    input  tap_data,
    input  tap_idx,
    input  tap_last,
    output tap_ready
  );

endinterface

// File: rtl/rbuf_tap_addr.sv
// Tap index counter and modulo-M buffer address generator.
// Ports:
//   clk, rst   clock, synchronous active-low reset
//   head       buffer slot of the newest sample of the window being read
//   start      begin a new burst (load the first tap index)
//   advance    current tap accepted, step to the next index
//   addr       buffer slot of the tap presented next cycle (from the next index)
//   tap_idx    index of the tap currently presented
//   last       current index is the final one of the burst
// Macro TAP_REVERSE_ORDER_EN: count M-1 down to 0 (oldest first) instead of up.
module rbuf_tap_addr
  import rbuf_pkg::*;
#(
  parameter int unsigned M  = DefM,
  parameter int unsigned AW = DefAW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] head,
  input  logic          start,
  input  logic          advance,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] tap_idx,
  output logic          last
);

`ifdef TAP_REVERSE_ORDER_EN
  localparam logic [AW-1:0] IdxFirst = AW'(M - 1);
  localparam logic [AW-1:0] IdxLast  = '0;
`else
  localparam logic [AW-1:0] IdxFirst = '0;
  localparam logic [AW-1:0] IdxLast  = AW'(M - 1);
`endif

  logic [AW-1:0] k_q, k_d;

  always_comb begin
    k_d = k_q;
    if (start) begin
      k_d = IdxFirst;
    end else if (advance) begin
`ifdef TAP_REVERSE_ORDER_EN
      k_d = k_q - 1'b1;
`else
      k_d = k_q + 1'b1;
`endif
    end
  end

  // Address is looked up from the next index so the data register can load it.
  assign addr    = AW'(mod_sub(32'(head), 32'(k_d), M));
  assign tap_idx = k_q;
  assign last    = (k_q == IdxLast);

  always_ff @(posedge clk) begin
    if (!rst) k_q <= '0;
    else      k_q <= k_d;
  end

endmodule

// File: rtl/rbuf_tap_reader.sv
// Sample history buffer, read side. Keeps the last M samples in a modulo-M
// circular buffer and, on each sample strobe, streams the whole window out one
// tap per valid/ready handshake to a time-shared FIR MAC.
// Ports:
//   clk, rst  clock, synchronous active-low reset
//   en, x     sample strobe and sample
//   busy      burst in progress
//   ovf       sticky: a pending sample was overwritten during a burst
//   tap       tap stream (master side)
// Macro TAP_REVERSE_ORDER_EN: stream oldest tap first (handled in rbuf_tap_addr).
module rbuf_tap_reader
  import rbuf_pkg::*;
#(
  parameter int unsigned M  = DefM,
  parameter int unsigned W  = DefW,
  parameter int unsigned AW = DefAW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [W-1:0]          x,
  output logic                  busy,
  output logic                  ovf,
  rbuf_tap_reader_if.master     tap
);

  state_e        state_q, state_d;
  logic [W-1:0]  mem_q [M];
  logic [AW-1:0] wr_ptr_q, head_q;
  logic          pend_valid_q, pend_valid_d;
  logic [W-1:0]  pend_data_q, pend_data_d;
  logic          ovf_q, ovf_d;
  logic          tap_valid_q;
  logic [W-1:0]  tap_data_q;

  logic          start, advance, xfer, last;
  logic [W-1:0]  commit_data;
  logic [AW-1:0] head_sel, addr, k;

  assign xfer     = tap_valid_q && tap.tap_ready;
  // A starting burst reads around the slot being written this cycle.
  assign head_sel = start ? wr_ptr_q : head_q;

  rbuf_tap_addr #(
    .M  (M),
    .AW (AW)
  ) u_tap_addr (
    .clk     (clk),
    .rst     (rst),
    .head    (head_sel),
    .start   (start),
    .advance (advance),
    .addr    (addr),
    .tap_idx (k),
    .last    (last)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRead;
      StRead:  if (xfer && last && !start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: burst start/advance and the sample to commit
  always_comb begin
    start       = 1'b0;
    advance     = 1'b0;
    commit_data = x;
    unique case (state_q)
      StIdle: start = en;
      StRead: begin
        advance = xfer && !last;
        // A strobe coinciding with the last transfer passes through pending
        // and is committed at once, so it wins over the held sample.
        start       = xfer && last && (pend_valid_q || en);
        commit_data = en ? x : pend_data_q;
      end
      default: ;
    endcase
  end

  // Pending sample and overflow flag
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    ovf_d        = ovf_q;
    if (state_q == StRead) begin
      if (start) begin
        pend_valid_d = 1'b0;
      end else if (en) begin
        pend_valid_d = 1'b1;
        pend_data_d  = x;
      end
      if (en && pend_valid_q) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(M); i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      head_q       <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
      tap_valid_q  <= 1'b0;
      tap_data_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      ovf_q        <= ovf_d;
      tap_valid_q  <= (state_d == StRead);
      if (start) begin
        mem_q[wr_ptr_q] <= commit_data;
        wr_ptr_q        <= AW'(mod_add(32'(wr_ptr_q), 32'd1, M));
        head_q          <= wr_ptr_q;
      end
      if (start || advance) begin
        // Bypass the slot written in the same cycle.
        tap_data_q <= (start && (addr == wr_ptr_q)) ? commit_data : mem_q[addr];
      end
    end
  end

  assign busy          = (state_q == StRead);
  assign ovf           = ovf_q;
  assign tap.tap_valid = tap_valid_q;
  assign tap.tap_data  = tap_data_q;
  assign tap.tap_idx   = k;
  assign tap.tap_last  = last && tap_valid_q;

endmodule

// File: tb/tb_rbuf_tap_reader.sv
// Directed bench for rbuf_tap_reader (M=6, W=12, AW=3). Inputs are driven and
// outputs sampled on the falling clock edge. Build with TAP_REVERSE_ORDER_EN to
// exercise oldest-first ordering; expected tap order is derived from it.
module tb_rbuf_tap_reader;

  localparam int unsigned M  = 6;
  localparam int unsigned W  = 12;
  localparam int unsigned AW = 3;
`ifdef TAP_REVERSE_ORDER_EN
  localparam bit Rev = 1'b1;
`else
  localparam bit Rev = 1'b0;
`endif
  localparam logic [AW-1:0] FirstIdx = Rev ? AW'(M - 1) : '0;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] x   = '0;
  logic         busy, ovf;

  rbuf_tap_reader_if #(.W(W), .AW(AW)) bus ();

  rbuf_tap_reader #(.M(M), .W(W), .AW(AW)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .x    (x),
    .busy (busy),
    .ovf  (ovf),
    .tap  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Burst capture, in arrival order
  logic [W-1:0]  got_d [M];
  logic [AW-1:0] got_i [M];
  logic          got_l [M];
  int            got_n, got_cyc;
  bit            got_drop, got_unstable;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [W-1:0] v);
    en = 1'b1;
    x  = v;
    step();
    en = 1'b0;
  endtask

  // Collect one burst. alt: ready toggles 1,0,...; e1/e2: cycle of the burst at
  // which a sample strobe (v1/v2) is raised, -1 for none.
  task automatic run_burst(input bit alt, input int e1, input logic [W-1:0] v1,
                           input int e2, input logic [W-1:0] v2);
    logic [W-1:0]  pd;
    logic [AW-1:0] pi;
    logic          pl;
    bit            hold;
    got_n = 0; got_cyc = 0; got_drop = 0; got_unstable = 0; hold = 0;
    pd = '0; pi = '0; pl = 1'b0;
    for (int w = 0; w < 10 && bus.tap_valid !== 1'b1; w++) step();
    for (int c = 0; c < 40 && got_n < int'(M); c++) begin
      if (c == e1) begin en = 1'b1; x = v1; end
      else if (c == e2) begin en = 1'b1; x = v2; end
      else en = 1'b0;
      bus.tap_ready = alt ? (c % 2 == 0) : 1'b1;
      if (bus.tap_valid !== 1'b1) got_drop = 1;
      if (hold && (bus.tap_data !== pd || bus.tap_idx !== pi || bus.tap_last !== pl))
        got_unstable = 1;
      if (bus.tap_ready) begin
        got_d[got_n] = bus.tap_data;
        got_i[got_n] = bus.tap_idx;
        got_l[got_n] = bus.tap_last;
        got_n++;
        hold = 0;
      end else begin
        hold = 1; pd = bus.tap_data; pi = bus.tap_idx; pl = bus.tap_last;
      end
      got_cyc++;
      step();
    end
    en = 1'b0;
    bus.tap_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; bus.tap_ready = 1'b1;
    step(); step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, bus.tap_valid, bus.tap_last, ovf} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {busy, bus.tap_valid, bus.tap_last, ovf});
    end
    checks++;
    if (bus.tap_data !== '0 || bus.tap_idx !== '0) begin
      failures++;
      $display("FAIL reset_data got data=%h idx=%0d want 0/0", bus.tap_data, bus.tap_idx);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] exp [M];
    foreach (exp[i]) exp[i] = '0;
    exp[0] = 12'h123;
    pulse(12'h123);
    checks++;
    if (bus.tap_valid !== 1'b1 || bus.tap_idx !== FirstIdx || bus.tap_data !== exp[FirstIdx]) begin
      failures++;
      $display("FAIL single_latency got v=%b idx=%0d d=%h want v=1 idx=%0d d=%h",
               bus.tap_valid, bus.tap_idx, bus.tap_data, FirstIdx, exp[FirstIdx]);
    end
    run_burst(0, -1, '0, -1, '0);
    checks++;
    if (got_n !== int'(M)) begin
      failures++; $display("FAIL single_count got=%0d want=%0d", got_n, M);
    end
    for (int p = 0; p < got_n; p++) begin
      int ei = Rev ? int'(M) - 1 - p : p;
      checks++;
      if ({got_i[p], got_d[p], got_l[p]} !== {AW'(ei), exp[ei], p == int'(M) - 1}) begin
        failures++;
        $display("FAIL single_tap%0d got idx=%0d d=%h last=%b want idx=%0d d=%h last=%b",
                 p, got_i[p], got_d[p], got_l[p], ei, exp[ei], p == int'(M) - 1);
      end
    end
    checks++;
    if (busy !== 1'b0 || bus.tap_valid !== 1'b0) begin
      failures++; $display("FAIL single_end got busy=%b v=%b want 0/0", busy, bus.tap_valid);
    end
  endtask

  // Seven samples through a six-deep buffer exercise the modulo wrap.
  task automatic test_wrap();
    logic [W-1:0] exp [M];
    do_reset();
    for (int s = 1; s <= 7; s++) begin
      pulse(W'(s));
      run_burst(0, -1, '0, -1, '0);
      checks++;
      if (got_n !== int'(M)) begin
        failures++; $display("FAIL wrap_count%0d got=%0d want=%0d", s, got_n, M);
      end
      step();
    end
    for (int k = 0; k < int'(M); k++) exp[k] = W'(7 - k);
    for (int p = 0; p < got_n; p++) begin
      int ei = Rev ? int'(M) - 1 - p : p;
      checks++;
      if ({got_i[p], got_d[p], got_l[p]} !== {AW'(ei), exp[ei], p == int'(M) - 1}) begin
        failures++;
        $display("FAIL wrap_tap%0d got idx=%0d d=%h last=%b want idx=%0d d=%h last=%b",
                 p, got_i[p], got_d[p], got_l[p], ei, exp[ei], p == int'(M) - 1);
      end
    end
  endtask

  // Continues from test_wrap: buffer {7,2,3,4,5,6}, next write at slot 1.
  task automatic test_backpressure();
    logic [W-1:0] exp [M];
    for (int k = 0; k < int'(M); k++) exp[k] = W'(8 - k);
    pulse(12'd8);
    run_burst(1, -1, '0, -1, '0);
    checks++;
    if (got_cyc !== 11 || got_drop || got_unstable) begin
      failures++;
      $display("FAIL bp_timing got cyc=%0d drop=%0d unstable=%0d want 11/0/0",
               got_cyc, got_drop, got_unstable);
    end
    for (int p = 0; p < got_n; p++) begin
      int ei = Rev ? int'(M) - 1 - p : p;
      checks++;
      if ({got_i[p], got_d[p]} !== {AW'(ei), exp[ei]}) begin
        failures++;
        $display("FAIL bp_tap%0d got idx=%0d d=%h want idx=%0d d=%h",
                 p, got_i[p], got_d[p], ei, exp[ei]);
      end
    end
  endtask

  // Pending sample during a burst: one (no ovf), two (ovf), one on the last tap.
  task automatic test_back_to_back();
    logic [W-1:0] v_first [3];
    logic [W-1:0] v_next  [3];
    logic [W-1:0] exp [M];
    bit           want_ovf [3];
    v_first  = '{12'h111, 12'h222, 12'h333};
    v_next   = '{12'hAAA, 12'hBBB, 12'h444};
    want_ovf = '{1'b0, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      do_reset();
      pulse(v_first[t]);
      if (t == 0)      run_burst(0, 2, 12'hAAA, -1, '0);
      else if (t == 1) run_burst(0, 1, 12'hAAA, 3, 12'hBBB);
      else             run_burst(0, int'(M) - 1, 12'h444, -1, '0);
      foreach (exp[i]) exp[i] = '0;
      exp[0] = v_first[t];
      for (int p = 0; p < got_n; p++) begin
        int ei = Rev ? int'(M) - 1 - p : p;
        checks++;
        if (got_d[p] !== exp[ei]) begin
          failures++;
          $display("FAIL b2b%0d_old_tap%0d got=%h want=%h", t, p, got_d[p], exp[ei]);
        end
      end
      checks++;
      if (bus.tap_valid !== 1'b1 || bus.tap_idx !== FirstIdx) begin
        failures++;
        $display("FAIL b2b%0d_restart got v=%b idx=%0d want v=1 idx=%0d",
                 t, bus.tap_valid, bus.tap_idx, FirstIdx);
      end
      run_burst(0, -1, '0, -1, '0);
      exp[0] = v_next[t];
      exp[1] = v_first[t];
      checks++;
      if (got_n !== int'(M)) begin
        failures++; $display("FAIL b2b%0d_count got=%0d want=%0d", t, got_n, M);
      end
      for (int p = 0; p < got_n; p++) begin
        int ei = Rev ? int'(M) - 1 - p : p;
        checks++;
        if ({got_i[p], got_d[p]} !== {AW'(ei), exp[ei]}) begin
          failures++;
          $display("FAIL b2b%0d_new_tap%0d got idx=%0d d=%h want idx=%0d d=%h",
                   t, p, got_i[p], got_d[p], ei, exp[ei]);
        end
      end
      checks++;
      if (ovf !== want_ovf[t] || busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b%0d_ovf got ovf=%b busy=%b want ovf=%b busy=0",
                 t, ovf, busy, want_ovf[t]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] exp [M];
    do_reset();
    pulse(12'h777);
    bus.tap_ready = 1'b1;
    for (int c = 0; c < 10 && bus.tap_idx !== 3'd3; c++) step();
    checks++;
    if (bus.tap_idx !== 3'd3 || bus.tap_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_reach got idx=%0d v=%b want idx=3 v=1", bus.tap_idx, bus.tap_valid);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bus.tap_valid, busy, bus.tap_last} !== 3'b000 || bus.tap_idx !== '0
        || bus.tap_data !== '0) begin
      failures++;
      $display("FAIL midrst_abort got v=%b busy=%b idx=%0d d=%h want 0/0/0/0",
               bus.tap_valid, busy, bus.tap_idx, bus.tap_data);
    end
    rst = 1'b1;
    step();
    checks++;
    if (bus.tap_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_idle got v=%b want 0", bus.tap_valid);
    end
    foreach (exp[i]) exp[i] = '0;
    exp[0] = 12'h055;
    pulse(12'h055);
    run_burst(0, -1, '0, -1, '0);
    checks++;
    if (got_n !== int'(M)) begin
      failures++; $display("FAIL midrst_count got=%0d want=%0d", got_n, M);
    end
    for (int p = 0; p < got_n; p++) begin
      int ei = Rev ? int'(M) - 1 - p : p;
      checks++;
      if ({got_i[p], got_d[p]} !== {AW'(ei), exp[ei]}) begin
        failures++;
        $display("FAIL midrst_tap%0d got idx=%0d d=%h want idx=%0d d=%h",
                 p, got_i[p], got_d[p], ei, exp[ei]);
      end
    end
  endtask

  initial begin
    bus.tap_ready = 1'b1;
    step();
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbuf_tap_reader.md
Name: rbuf_tap_reader

Overview:
Read-side counterpart of the sample history buffer. Stores the last M input samples in a modulo-M circular buffer. On each new sample strobe it streams the M-sample window out one tap per handshake (valid/ready), newest first, to feed a single time-shared FIR MAC. Sits between the ADC sample strobe and the filter datapath.

Parameters:
M, 6, window length (number of taps), M >= 2
W, 12, sample width in bits
AW, 3, tap index/pointer width, 2^AW >= M

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-low reset
en  in  1  sample strobe: x is valid this cycle
x  in  W  input sample
busy  out  1  burst in progress (state != IDLE)
tap_valid  out  1  tap_data/tap_idx valid
tap_ready  in  1  downstream accepts tap this cycle
tap_data  out  W  sample value for tap tap_idx
tap_idx  out  AW  0 = newest sample, M-1 = oldest
tap_last  out  1  high with the final tap of a burst
ovf  out  1  sticky: pending sample overwritten while busy

Behaviour:
- Reset (rst==0 at a clk edge): all M buffer entries = 0, wr_ptr = 0, pending empty, state IDLE; busy, tap_valid, tap_last, ovf = 0; tap_data = 0, tap_idx = 0. Reset overrides everything, including a mid-burst state; the burst is abandoned with no further taps.
- FSM: IDLE, READ.
- IDLE with en=1: write x at wr_ptr; head = wr_ptr; wr_ptr = (wr_ptr+1) mod M; go to READ. Latency is 1: the next cycle has tap_valid=1, tap_idx=0, tap_data=x.
- READ: the tap at index k is mem[(head - k) mod M]. Pointer wrap is modulo M, not 2^AW. Outputs are registered.
- Handshake: a tap transfers when tap_valid && tap_ready. Without a transfer, tap_data, tap_idx and tap_last hold stable. tap_valid never drops mid-burst.
- tap_last = 1 exactly when tap_idx == M-1.
- On the transfer of the last tap: if pending is full, commit the pending sample exactly as in IDLE with en=1 and clear pending; the new burst's idx 0 appears on the next cycle with tap_valid continuously high. Otherwise go to IDLE with tap_valid=0 on the next cycle.
- en while busy: x goes into a one-deep pending register, so the buffer is not modified during a burst (snapshot-consistent window).
- en while busy with pending already full: pending is overwritten with the new x and ovf is set to 1. ovf clears only on reset.
- en in the same cycle as the last-tap transfer: treated as en while busy, i.e. goes to pending, then is committed immediately.
- After reset, history entries read as 0 until M samples have been written. There is no separate fill count.
- Burst length is always exactly M taps.

Optional Feature:
TAP_REVERSE_ORDER_EN
- Defined: taps stream oldest first, so tap_idx counts M-1 down to 0 and tap_last is asserted with tap_idx==0. Data at a given tap_idx is unchanged.
- Undefined: newest first, as specified above.
- Latency, handshake and pending behaviour are identical in both builds.

Decomposition:
- Package rbuf_pkg: default M/W/AW constants, the state enum (IDLE, READ), and a modulo-M add/subtract function.
- One sub-module: rbuf_tap_addr, combinational-plus-register tap index counter and modulo-M address generator. Inputs: head, start, advance. Outputs: addr, tap_idx, last.

Test Plan:
1. Reset, then en with x=0x123, tap_ready=1 -> cycle+1 through +6: tap_data 0x123,0,0,0,0,0; idx 0..5; tap_last on idx 5; busy=0 at cycle+7.
2. Seven spaced en with x=1..7, ready=1 -> the burst after sample 7 is 7,6,5,4,3,2 (checks mod-6 wrap).
3. Burst with tap_ready alternating 1,0 -> data/idx stable during ready=0 cycles; burst takes 11 cycles; tap_valid is never low mid-burst.
4. en x=0xAAA during a burst -> the current burst shows the old window unchanged; the next burst starts back-to-back with idx0=0xAAA; ovf=0. Repeat with 0xAAA then 0xBBB in the same burst -> ovf=1; head is 0xBBB; 0xAAA never appears.
5. rst low at tap_idx=3 -> the next cycle has tap_valid=0, busy=0; a following en x=0x055 gives burst 0x055,0,0,0,0,0.
6. TAP_REVERSE_ORDER_EN defined with the scenario 2 stimulus -> order 2,3,4,5,6,7; idx 5..0; tap_last with 7.
